// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment lookup,
// scan state encoding and display constants.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] BLANK_SEG = 7'b1111111;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    // Hex nibble to active-low segments {a,b,c,d,e,f,g}.
    function automatic logic [SEG_W-1:0] seg(input logic [3:0] digit);
        logic [SEG_W-1:0] pattern;
        case (digit)
            4'h0:    pattern = 7'b0000001;
            4'h1:    pattern = 7'b1001111;
            4'h2:    pattern = 7'b0010010;
            4'h3:    pattern = 7'b0000110;
            4'h4:    pattern = 7'b1001100;
            4'h5:    pattern = 7'b0100100;
            4'h6:    pattern = 7'b0100000;
            4'h7:    pattern = 7'b0001111;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0000100;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b1100000;
            4'hC:    pattern = 7'b0110001;
            4'hD:    pattern = 7'b1000010;
            4'hE:    pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a rising-edge pulse; the pulse is combinational so
// the consumer acts on the third edge after the input is first sampled high.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic meta;
    logic sync;
    logic sync_d;
    logic ready;
    logic armed;

    // armed only after the input has been seen low post-reset, so a level
    // already high at release never counts as an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            ready  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            ready  <= 1'b1;
            armed  <= armed | (ready & ~meta);
        end
    end

    assign rise_c = sync & ~sync_d & armed;

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Up/down 16-bit counter shown on a four-digit multiplexed seven-segment display
// with per-slot blanking and tear-free nibble snapshots.
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        up,
    input  logic        down,
    output logic [15:0] value,
    output logic [6:0]  LED_out,
    output logic [3:0]  anode
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    logic              inc_c;
    logic              dec_c;
    logic [PW-1:0]     presc;
    logic [1:0]        digit_sel;
    logic              slot_end_c;
    scan_state_e       state_q;
    scan_state_e       state_d;
    logic              load_snap_c;
    logic [3:0]        snapshot;
    logic [3:0]        anode_d;
    logic [SEG_W-1:0]  led_d;

    sync_edge_detect u_up_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (up),
        .rise_c (inc_c)
    );

    sync_edge_detect u_down_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (down),
        .rise_c (dec_c)
    );

    // Counter: simultaneous requests cancel, disabled requests are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= 16'h0000;
        end else if (enable && (inc_c ^ dec_c)) begin
            value <= inc_c ? value + 16'd1 : value - 16'd1;
        end
    end

    assign slot_end_c = (presc == PRESC_LAST);

    // Slot timing and digit rotation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            digit_sel <= 2'd0;
        end else if (slot_end_c) begin
            presc     <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            presc     <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_BLANK;
            snapshot <= 4'h0;
            anode    <= 4'b0000;
            LED_out  <= BLANK_SEG;
        end else begin
            state_q  <= state_d;
            anode    <= anode_d;
            LED_out  <= led_d;
            if (load_snap_c) begin
                snapshot <= value[{digit_sel, 2'b00} +: 4];
            end
        end
    end

    // Scan next-state, snapshot strobe and output decode from the current state
    always_comb begin
        state_d     = state_q;
        load_snap_c = 1'b0;
        anode_d     = 4'b0000;
        led_d       = BLANK_SEG;
        case (state_q)
            S_BLANK: begin
                if (presc == BLANK_LAST) begin
                    state_d     = S_DRIVE;
                    load_snap_c = 1'b1;
                end
            end
            S_DRIVE: begin
                anode_d = 4'b0001 << digit_sel;
                led_d   = seg(snapshot);
                if (slot_end_c) begin
                    state_d = S_BLANK;
                end
            end
            default: state_d = S_BLANK;
        endcase
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for the scan controller with an 8-cycle slot and 2-cycle blank.
module tb_seven_seg_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        up;
    logic        down;
    logic [15:0] value;
    logic [6:0]  LED_out;
    logic [3:0]  anode;

    int vectors;
    int miscompares;
    int k;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] BLANK = 7'b1111111;

    seven_seg_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .up      (up),
        .down    (down),
        .value   (value),
        .LED_out (LED_out),
        .anode   (anode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected scan outputs for the current cycle index k (k=1 is the first edge after release)
    task automatic scan_check(input logic [27:0] leds);
        int ph;
        int dig;
        ph  = (k - 1) % 8;
        dig = ((k - 1) / 8) % 4;
        if (ph < 2) begin
            chk("anode_blank", 16'(anode), 16'h0000);
            chk("led_blank", 16'(LED_out), 16'(BLANK));
        end else begin
            chk("anode_drive", 16'(anode), 16'(4'b0001 << dig));
            chk("led_drive", 16'(LED_out), 16'(leds[dig*7 +: 7]));
        end
        chk("onehot", 16'($countones(anode) <= 1), 16'h0001);
    endtask

    task automatic press_up();
        up = 1'b1;
        repeat (4) tick();
        up = 1'b0;
        repeat (4) tick();
    endtask

    task automatic press_down();
        down = 1'b1;
        repeat (4) tick();
        down = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        up          = 1'b0;
        down        = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_value", value, 16'h0000);
        chk("rst_anode", 16'(anode), 16'h0000);
        chk("rst_led", 16'(LED_out), 16'(BLANK));
        rst_n = 1'b1;
        k = 0;

        // Full scan round with value 0
        repeat (32) begin
            tick();
            scan_check({SEG_0, SEG_0, SEG_0, SEG_0});
        end

        // Held level gives one increment, on the third edge after first sample
        enable = 1'b1;
        up = 1'b1;
        tick();
        chk("hold_e1", value, 16'h0000);
        tick();
        chk("hold_e2", value, 16'h0000);
        tick();
        chk("hold_e3", value, 16'h0001);
        repeat (17) tick();
        chk("hold_end", value, 16'h0001);
        up = 1'b0;
        repeat (4) tick();

        // Decrement through zero wraps to 0xFFFF; all digits show F
        press_down();
        chk("dec_to_0", value, 16'h0000);
        press_down();
        chk("dec_wrap", value, 16'hFFFF);
        repeat (32) tick();
        repeat (32) begin
            tick();
            scan_check({SEG_F, SEG_F, SEG_F, SEG_F});
        end

        // Increment wraps to zero; simultaneous presses cancel
        press_up();
        chk("inc_wrap", value, 16'h0000);
        up = 1'b1;
        down = 1'b1;
        repeat (6) tick();
        chk("simul_held", value, 16'h0000);
        up = 1'b0;
        down = 1'b0;
        repeat (4) tick();
        chk("simul_after", value, 16'h0000);

        // Disabled presses are discarded, not queued
        enable = 1'b0;
        repeat (3) press_up();
        chk("dis_presses", value, 16'h0000);
        enable = 1'b1;
        repeat (8) tick();
        chk("dis_no_queue", value, 16'h0000);
        press_up();
        chk("reenable_inc", value, 16'h0001);

        // Tear-free display: 9 -> A during digit-0 drive
        repeat (8) press_up();
        chk("value_9", value, 16'h0009);
        while ((k % 32) != 3) tick();
        chk("tear_led_k3", 16'(LED_out), 16'(SEG_9));
        up = 1'b1;
        repeat (5) begin
            tick();
            chk("tear_anode", 16'(anode), 16'h0001);
            chk("tear_led", 16'(LED_out), 16'(SEG_9));
        end
        chk("value_A", value, 16'h000A);
        up = 1'b0;
        while ((k % 32) != 3) tick();
        chk("next_slot_led", 16'(LED_out), 16'(SEG_A));
        repeat (5) begin
            tick();
            scan_check({SEG_0, SEG_0, SEG_0, SEG_A});
        end

        // Mid-slot reset with a press in flight that is still high at release
        while ((k % 8) != 5) tick();
        chk("pre_rst_anode", 16'(anode), 16'h0002);
        up = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_anode", 16'(anode), 16'h0000);
        chk("midrst_led", 16'(LED_out), 16'(BLANK));
        chk("midrst_value", value, 16'h0000);
        tick();
        rst_n = 1'b1;
        k = 0;
        repeat (8) begin
            tick();
            scan_check({SEG_0, SEG_0, SEG_0, SEG_0});
        end
        chk("high_at_release", value, 16'h0000);
        up = 1'b0;
        repeat (3) tick();
        press_up();
        chk("post_rst_inc", value, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_controller.md
SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, meaning dead-time cycles at the start of each slot (legal range 1..REFRESH_DIV-2).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 enable  input  1  when high, up/down presses modify the counter.
REQ-006 up  input  1  asynchronous level input; each rising edge is one increment request.
REQ-007 down  input  1  asynchronous level input; each rising edge is one decrement request.
REQ-008 value  output  16  current counter value, registered.
REQ-009 LED_out  output  7  segments {a,b,c,d,e,f,g} in bits [6:0], active-low, registered.
REQ-010 anode  output  4  digit select, one-hot active-high or all-zero, registered.

Function
REQ-011 up and down SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-012 The counter SHALL update on the third rising clk edge after the input is first sampled high.
REQ-013 Increment pulse with enable=1 SHALL set value to value+1 mod 2^16 (0xFFFF wraps to 0x0000).
REQ-014 Decrement pulse with enable=1 SHALL set value to value-1 mod 2^16 (0x0000 wraps to 0xFFFF).
REQ-015 Simultaneous up and down pulses in the same cycle SHALL leave value unchanged.
REQ-016 Pulses arriving while enable=0 SHALL be discarded, not queued.
REQ-017 A level held high SHALL produce exactly one request.
REQ-018 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its wrap marks the end of a slot.
REQ-019 digit_sel (2 bits) SHALL advance 0->1->2->3->0 at each slot end.
REQ-020 The scan FSM SHALL have two states, S_BLANK and S_DRIVE.
REQ-021 S_BLANK SHALL hold while prescaler < BLANK_CYCLES; S_DRIVE SHALL hold for prescaler in BLANK_CYCLES..REFRESH_DIV-1; at slot end the FSM returns to S_BLANK.
REQ-022 On the S_BLANK->S_DRIVE transition the block SHALL snapshot nibble value[4*digit_sel+3 : 4*digit_sel]; that snapshot is displayed for the whole of S_DRIVE, so counter changes mid-slot do not tear.
REQ-023 anode and LED_out SHALL lag the FSM state by exactly one cycle.
REQ-024 In S_BLANK the outputs SHALL be anode=4'b0000 and LED_out=7'b1111111.
REQ-025 In S_DRIVE the outputs SHALL be anode=1<<digit_sel and LED_out=SEG(snapshot).
REQ-026 SEG, digits 0-7: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-027 SEG, digits 8-F: 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-028 anode SHALL never have more than one bit set in any cycle.

Reset
REQ-029 With rst_n=0 at a clk edge: value=0, prescaler=0, digit_sel=0, state=S_BLANK, snapshot=0, and synchronizer/edge flops=0.
REQ-030 The same reset edge SHALL set anode=4'b0000 and LED_out=7'b1111111.
REQ-031 Reset asserted mid-slot or mid-press SHALL take effect at that edge; a press in flight is lost.
REQ-032 After release, digit 0 slot SHALL begin immediately with prescaler=0.
REQ-033 An input already high at release SHALL NOT generate a request.

Structure
REQ-034 A shared package seven_seg_pkg SHALL hold the SEG lookup function (4-bit in, 7-bit out), the scan state enum {S_BLANK, S_DRIVE}, and constants BLANK_SEG=7'b1111111 and NUM_DIGITS=4.
REQ-035 One sub-module, sync_edge_detect (2-flop synchronizer plus rising-edge pulse, clk/rst_n), SHALL be instantiated twice, for up and for down.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-036 Reset then value=0x0000 -> anode sequence per 8-cycle slot: 0000 for 2 cycles then 0001 for 6 cycles with LED_out=0000001; then slots for 0010, 0100, 1000; no multi-hot anode ever.
REQ-037 Scenario: enable=1, up high for 20 cycles -> value=0x0001 exactly, updated 3 edges after first sample.
REQ-038 Scenario: value=0x0000, one down press -> value=0xFFFF; all four digits show 0111000.
REQ-039 Scenario: value=0xFFFF, one up press -> value=0x0000; up and down rising in the same cycle -> value unchanged.
REQ-040 Scenario: enable=0, three up presses, then enable=1 -> value unchanged, with no delayed increments.
REQ-041 Scenario: increment value 0x0009->0x000A during the digit-0 S_DRIVE -> LED_out stays 0000100 for that slot and shows 0001000 in the next digit-0 slot; rst_n=0 mid-slot -> outputs blank at the next edge.
